mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-ported unified memory between instruction fetch (IF) and the load/store path of the memory-access stage. Arbitrates the two requesters, drives a hold-until-ready memory handshake, and returns registered read data and per-requester completion pulses. Loads/stores have priority, with a bounded-starvation guarantee for fetch. Honours pipeline halt and branch flush.

## Interface
- `XLEN`, from define.sv: address/data width (32).
- STARVE_MAX, 4: consecutive LS grants allowed while IF waits, 1..7.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- halt  in  1  high blocks new grants; in-flight access completes.
- flush  in  1  taken branch; suppresses IF response of the in-flight or same-cycle-completing fetch.
- if_req  in  1  fetch request, held with if_addr until if_gnt.
- if_addr  in  XLEN  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  XLEN  fetched instruction.
- ls_req  in  1  load/store request, held with attributes until ls_gnt.
- ls_we  in  1  1 = store.
- ls_addr  in  XLEN  data address.
- ls_wdata  in  XLEN  store data.
- ls_be  in  4  byte enables, pre-aligned by the requester.
- ls_gnt  out  1  one-cycle pulse: LS accepted.
- ls_rvalid  out  1  one-cycle pulse: load data valid or store acknowledged.
- ls_rdata  out  XLEN  load data; 0 on store ack.
- mem_req  out  1  memory access active.
- mem_we, mem_addr, mem_wdata, mem_be  out  1/XLEN/XLEN/4  access attributes; mem_we=0, mem_be=4'hF for fetch.
- mem_ready  in  1  access completes at this edge; mem_rdata valid.
- mem_rdata  in  XLEN  read data.

## Operation
- FSM states IDLE, BUSY_IF, BUSY_LS; reset to IDLE.
- Arbitration runs at every edge where state is IDLE, or BUSY_x with mem_ready=1 (completion edge), and halt=0.
- Winner: LS if only ls_req; IF if only if_req; both: LS unless starve_cnt == STARVE_MAX, then IF.
- starve_cnt (3 bit): +1 on an LS grant while if_req=1; cleared on any IF grant; saturates at STARVE_MAX.
- On grant: register mem_* from the winner's inputs, assert winner's gnt for one cycle, enter BUSY_winner.
- BUSY_x: mem_req=1, attributes frozen until mem_ready sampled 1.
- Completion edge: capture mem_rdata into x_rdata (LS store: 0), pulse x_rvalid one cycle; then grant next winner (back-to-back, mem_req stays 1) or go IDLE with mem_req=0.
- flush=1 on any cycle from IF grant through completion edge: the memory access still completes, if_rvalid suppressed, if_rdata unchanged. IF requests presented with flush=1 are not granted. LS is never affected by flush.
- halt=1: no grants. An in-flight access completes normally, and rvalid is still delivered.
- Fetch has no write path; ls_* inputs ignored unless ls_req=1.

## Timing
- Reset values: state IDLE; mem_req, mem_we, gnts, rvalids 0; mem_addr, mem_wdata, rdata 0; mem_be 0; starve_cnt 0.
- Reset mid-access: mem_req drops asynchronously and the access is abandoned with no rvalid.
- Req sampled at edge N → gnt and mem_req high in cycle N+1.
- mem_ready sampled high at edge M → rvalid high in cycle M+1.
- Zero-wait memory (mem_ready=1 in the first BUSY cycle): 2 cycles req→rvalid, 1 access per cycle sustained.
- gnt and rvalid may both be high in the same cycle, for the same or different requesters.
- Requesters must drop or change req in the cycle after gnt. A req still high in IDLE is treated as a new request.

## Structure
- Package mem_arb_pkg: state enum (IDLE, BUSY_IF, BUSY_LS), requester id enum (REQ_IF, REQ_LS), BE_FULL = 4'hF.
- Sub-module mem_arb_prio: combinational winner selection plus the starve_cnt register. Inputs are if_req, ls_req, halt, flush and arbitration-enable; outputs are the grant id and a grant-valid flag.
- The top level holds the FSM, the memory attribute registers and the response registers.

## Test plan
- Single load, mem_ready after 3 wait cycles, mem_rdata=32'hDEADBEEF → ls_gnt in cycle 1, mem_req high for cycles 1-4, ls_rvalid with 32'hDEADBEEF in cycle 5.
- Both requesting continuously, zero-wait memory, STARVE_MAX=4 → grant sequence LS,LS,LS,LS,IF repeating; mem_req never drops.
- Store to 0x100, wdata 0x12345678, be=4'b0011 → mem_we=1 and attributes stable until mem_ready; ls_rvalid with ls_rdata=0.
- Fetch in flight, flush pulsed one cycle before mem_ready → no if_rvalid, if_rdata unchanged, next LS granted at the completion edge.
- halt=1 with both requests pending → no gnt. halt released → LS granted the next cycle.
- rst_n low while BUSY_LS → mem_req 0 immediately, no ls_rvalid; after release, state IDLE and starve_cnt 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    // Address and data width of the unified memory.
    localparam int XLEN = 32;

    // Fetches always read a whole word.
    localparam logic [3:0] BE_FULL = 4'hF;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } arb_state_e;

    // Requester identities. The values double as per-requester indices.
    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_e;

    // Saturating increment of the 3-bit starvation counter.
    function automatic logic [2:0] starve_sat_inc(input logic [2:0] cnt,
                                                  input logic [2:0] lim);
        starve_sat_inc = (cnt >= lim) ? lim : cnt + 3'd1;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection for the memory port: load/store has priority, but a
// waiting fetch is forced through after STARVE_MAX consecutive LS grants.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    if_req,
    input  logic    ls_req,
    input  logic    halt,
    input  logic    flush,
    input  logic    arb_en,
    output req_id_e gnt_id,
    output logic    gnt_valid
);

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    logic [2:0] starve_reg;
    logic [2:0] starve_next;
    logic       if_eligible;
    logic       arb_open;
    logic       if_wins;

    // A fetch presented together with a flush is for the wrong path.
    assign if_eligible = if_req & ~flush;
    assign arb_open    = arb_en & ~halt;
    assign if_wins     = if_eligible & (~ls_req | (starve_reg == STARVE_LIM));
    assign gnt_valid   = arb_open & (if_eligible | ls_req);
    assign gnt_id      = if_wins ? REQ_IF : REQ_LS;

    // Count LS grants that overtook a waiting fetch; any fetch grant clears.
    always_comb begin
        starve_next = starve_reg;
        if (gnt_valid) begin
            if (gnt_id == REQ_IF) begin
                starve_next = '0;
            end else if (if_req) begin
                starve_next = starve_sat_inc(starve_reg, STARVE_LIM);
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_reg <= '0;
        end else begin
            starve_reg <= starve_next;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported unified memory between instruction fetch and the
// load/store path. Holds the access FSM, the registered memory attributes
// (frozen while an access waits for mem_ready) and the per-requester
// grant/response registers.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            halt,
    input  logic            flush,
    // fetch port
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    // load/store port
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    input  logic [3:0]      ls_be,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [XLEN-1:0] ls_rdata,
    // memory port
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_BUSY_IF = BUSY_IF;
    localparam logic [1:0] S_BUSY_LS = BUSY_LS;

    logic [1:0]      state_reg;
    logic            mem_req_reg;
    logic            mem_we_reg;
    logic [XLEN-1:0] mem_addr_reg;
    logic [XLEN-1:0] mem_wdata_reg;
    logic [3:0]      mem_be_reg;
    logic            flush_pend_reg;

    logic            busy;
    logic            done;
    logic            arb_en;
    logic            if_squash;
    req_id_e         cur_id;
    req_id_e         gnt_id;
    logic            gnt_valid;

    assign busy      = (state_reg != S_IDLE);
    assign done      = busy & mem_ready;
    // Arbitrate when the port is free or frees up at this edge.
    assign arb_en    = ~busy | mem_ready;
    assign cur_id    = (state_reg == S_BUSY_LS) ? REQ_LS : REQ_IF;
    // A flush anywhere in the fetch's lifetime, including its completion
    // cycle, throws the fetched word away.
    assign if_squash = flush_pend_reg | flush;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .ls_req    (ls_req),
        .halt      (halt),
        .flush     (flush),
        .arb_en    (arb_en),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    // Access FSM and memory attribute registers; a grant at a completion
    // edge overrides the return to IDLE so mem_req stays high back-to-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_be_reg     <= '0;
            flush_pend_reg <= 1'b0;
        end else begin
            if ((state_reg == S_BUSY_IF) && flush) begin
                flush_pend_reg <= 1'b1;
            end
            if (done) begin
                state_reg   <= S_IDLE;
                mem_req_reg <= 1'b0;
            end
            if (gnt_valid) begin
                mem_req_reg    <= 1'b1;
                flush_pend_reg <= 1'b0;
                if (gnt_id == REQ_LS) begin
                    state_reg     <= S_BUSY_LS;
                    mem_we_reg    <= ls_we;
                    mem_addr_reg  <= ls_addr;
                    mem_wdata_reg <= ls_wdata;
                    mem_be_reg    <= ls_be;
                end else begin
                    state_reg     <= S_BUSY_IF;
                    mem_we_reg    <= 1'b0;
                    mem_addr_reg  <= if_addr;
                    mem_wdata_reg <= '0;
                    mem_be_reg    <= BE_FULL;
                end
            end
        end
    end

    // One grant/response register set per requester (index = req_id_e value).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            localparam req_id_e ID = (gi == 0) ? REQ_IF : REQ_LS;

            logic            gnt_reg;
            logic            rvalid_reg;
            logic [XLEN-1:0] rdata_reg;
            logic            deliver;
            logic [XLEN-1:0] rdata_next;

            assign deliver    = done && (cur_id == ID) && !((ID == REQ_IF) && if_squash);
            // Store acknowledgements return zero data.
            assign rdata_next = ((ID == REQ_LS) && mem_we_reg) ? '0 : mem_rdata;

            // Grant and completion pulses plus the held read data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    gnt_reg    <= 1'b0;
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    gnt_reg    <= gnt_valid && (gnt_id == ID);
                    rvalid_reg <= deliver;
                    if (deliver) begin
                        rdata_reg <= rdata_next;
                    end
                end
            end
        end
    endgenerate

    assign if_gnt    = g_resp[0].gnt_reg;
    assign if_rvalid = g_resp[0].rvalid_reg;
    assign if_rdata  = g_resp[0].rdata_reg;
    assign ls_gnt    = g_resp[1].gnt_reg;
    assign ls_rvalid = g_resp[1].rvalid_reg;
    assign ls_rdata  = g_resp[1].rdata_reg;

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_be    = mem_be_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level reference model
// checked against the DUT every cycle, plus hand-computed literal checks.
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt, flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [31:0] ls_addr, ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] rdata_base;
    int          wait_n;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .halt      (halt),
        .flush     (flush),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_be     (ls_be),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial forever #5 clk = ~clk;

    // Memory returns a word derived from the address being accessed.
    assign mem_rdata = rdata_base ^ mem_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Memory responder: mem_ready after wait_n wait cycles of each access.
    int rcnt;
    initial begin
        mem_ready = 1'b0;
        rcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                rcnt = 0;
                mem_ready = 1'b0;
            end else begin
                if (if_gnt || ls_gnt) rcnt = 0;
                else if (mem_req) rcnt++;
                mem_ready = mem_req && (rcnt == wait_n);
            end
        end
    end

    // Reference model: one outstanding access record, priority rules applied
    // directly to the sampled requests.
    int          m_cur;      // 0 none, 1 fetch, 2 load/store
    int          m_starve;
    bit          m_flushed;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        e_if_gnt, e_ls_gnt, e_if_rvalid, e_ls_rvalid, e_mem_req;
    logic [31:0] e_if_rdata, e_ls_rdata;
    bit          want_if;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_cur = 0; m_starve = 0; m_flushed = 0;
            m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0;
            e_if_gnt = 0; e_ls_gnt = 0; e_if_rvalid = 0; e_ls_rvalid = 0;
            e_if_rdata = 0; e_ls_rdata = 0; e_mem_req = 0;
        end else begin
            e_if_gnt = 0; e_ls_gnt = 0; e_if_rvalid = 0; e_ls_rvalid = 0;
            if (m_cur == 1 && flush) m_flushed = 1;
            if (m_cur != 0 && mem_ready) begin
                if (m_cur == 2) begin
                    e_ls_rvalid = 1;
                    e_ls_rdata  = m_we ? 32'h0 : (rdata_base ^ m_addr);
                end else if (!m_flushed) begin
                    e_if_rvalid = 1;
                    e_if_rdata  = rdata_base ^ m_addr;
                end
                m_cur = 0;
            end
            if (m_cur == 0 && !halt) begin
                want_if = if_req && !flush;
                if (want_if && (!ls_req || m_starve == STARVE_MAX)) begin
                    m_starve = 0; m_cur = 1; m_flushed = 0;
                    m_we = 0; m_addr = if_addr; m_wdata = 0; m_be = 4'hF;
                    e_if_gnt = 1;
                end else if (ls_req) begin
                    if (if_req && m_starve < STARVE_MAX) m_starve++;
                    m_cur = 2; m_flushed = 0;
                    m_we = ls_we; m_addr = ls_addr; m_wdata = ls_wdata; m_be = ls_be;
                    e_ls_gnt = 1;
                end
            end
            e_mem_req = (m_cur != 0);
        end
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("if_gnt",    32'(if_gnt),    32'(e_if_gnt));
            chk("ls_gnt",    32'(ls_gnt),    32'(e_ls_gnt));
            chk("if_rvalid", 32'(if_rvalid), 32'(e_if_rvalid));
            chk("ls_rvalid", 32'(ls_rvalid), 32'(e_ls_rvalid));
            chk("if_rdata",  if_rdata,       e_if_rdata);
            chk("ls_rdata",  ls_rdata,       e_ls_rdata);
            chk("mem_req",   32'(mem_req),   32'(e_mem_req));
            chk("mem_we",    32'(mem_we),    32'(m_we));
            chk("mem_addr",  mem_addr,       m_addr);
            chk("mem_wdata", mem_wdata,      m_wdata);
            chk("mem_be",    32'(mem_be),    32'(m_be));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; halt = 0; flush = 0;
        if_req = 0; if_addr = 0;
        ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0; ls_be = 4'hF;
        rdata_base = 32'hDEADBEEF; wait_n = 0;
        step(); step();
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_be",  32'(mem_be),  32'h0);
        chk("rst_ls_gnt",  32'(ls_gnt),  32'h0);
        rst_n = 1'b1;
        step();

        // Single load with 3 wait cycles
        wait_n = 3; ls_req = 1; ls_we = 0; ls_addr = 32'h0;
        step();
        chk("t1_ls_gnt_c1", 32'(ls_gnt), 32'h1);
        chk("t1_mem_req_c1", 32'(mem_req), 32'h1);
        ls_req = 0; ls_addr = 32'hFFFF_FFF0;
        step(); step(); step();
        chk("t1_mem_req_c4", 32'(mem_req), 32'h1);
        chk("t1_rvalid_c4", 32'(ls_rvalid), 32'h0);
        step();
        chk("t1_rvalid_c5", 32'(ls_rvalid), 32'h1);
        chk("t1_rdata_c5", ls_rdata, 32'hDEADBEEF);
        chk("t1_mem_req_c5", 32'(mem_req), 32'h0);
        step();

        // Both requesting, zero-wait: LS,LS,LS,LS,IF repeating
        wait_n = 0; if_addr = 32'h1000; ls_addr = 32'h2000;
        if_req = 1; ls_req = 1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t2_seq_if", 32'(if_gnt), (k % 5 == 4) ? 32'h1 : 32'h0);
            chk("t2_seq_ls", 32'(ls_gnt), (k % 5 == 4) ? 32'h0 : 32'h1);
            chk("t2_mem_req", 32'(mem_req), 32'h1);
            if (ls_gnt) ls_addr = ls_addr + 32'd4;
            if (if_gnt) if_addr = if_addr + 32'd4;
        end
        if_req = 0; ls_req = 0;
        step(); step();

        // Store with frozen attributes
        wait_n = 2; ls_req = 1; ls_we = 1; ls_addr = 32'h100;
        ls_wdata = 32'h12345678; ls_be = 4'b0011;
        step();
        chk("t3_ls_gnt", 32'(ls_gnt), 32'h1);
        chk("t3_mem_we", 32'(mem_we), 32'h1);
        ls_req = 0; ls_we = 0; ls_addr = 32'hBAD0; ls_wdata = 0; ls_be = 4'hF;
        step(); step();
        chk("t3_addr_hold", mem_addr, 32'h100);
        chk("t3_wdata_hold", mem_wdata, 32'h12345678);
        chk("t3_be_hold", 32'(mem_be), 32'h3);
        step();
        chk("t3_rvalid", 32'(ls_rvalid), 32'h1);
        chk("t3_rdata_zero", ls_rdata, 32'h0);
        step();

        // Fetch flushed one cycle before mem_ready; LS waiting behind it
        wait_n = 2; if_addr = 32'h200; if_req = 1;
        step();
        chk("t4_if_gnt", 32'(if_gnt), 32'h1);
        chk("t4_if_be", 32'(mem_be), 32'hF);
        if_req = 0; ls_req = 1; ls_addr = 32'h300;
        step();
        flush = 1;
        step();
        flush = 0;
        step();
        chk("t4_no_if_rvalid", 32'(if_rvalid), 32'h0);
        chk("t4_if_rdata_kept", if_rdata, 32'hDEADAEEB);
        chk("t4_ls_gnt", 32'(ls_gnt), 32'h1);
        chk("t4_mem_addr", mem_addr, 32'h300);
        ls_req = 0;
        step(); step(); step();
        chk("t4_ls_rdata", ls_rdata, 32'hDEADBDEF);
        step();

        // Halt holds off both requests
        wait_n = 2; halt = 1; if_addr = 32'h400; ls_addr = 32'h500;
        if_req = 1; ls_req = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t5_halt_if_gnt", 32'(if_gnt), 32'h0);
            chk("t5_halt_ls_gnt", 32'(ls_gnt), 32'h0);
        end
        halt = 0;
        step();
        chk("t5_ls_first", 32'(ls_gnt), 32'h1);
        ls_req = 0;
        step(); step(); step();
        chk("t5_if_gnt", 32'(if_gnt), 32'h1);
        chk("t5_ls_rvalid", 32'(ls_rvalid), 32'h1);
        chk("t5_ls_rdata", ls_rdata, 32'hDEADBBEF);
        if_req = 0;
        step(); step(); step();
        chk("t5_if_rvalid", 32'(if_rvalid), 32'h1);
        chk("t5_if_rdata", if_rdata, 32'hDEADBAEF);
        step();

        // Reset while an LS access is in flight
        wait_n = 3; ls_we = 0; if_addr = 32'h700; ls_addr = 32'h600;
        if_req = 1; ls_req = 1;
        step();
        chk("t6_ls_gnt", 32'(ls_gnt), 32'h1);
        ls_addr = 32'h604;
        step();
        rst_n = 0;
        #1;
        chk("t6_rst_mem_req", 32'(mem_req), 32'h0);
        chk("t6_rst_ls_rvalid", 32'(ls_rvalid), 32'h0);
        step();
        rst_n = 1; wait_n = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t6_seq_if", 32'(if_gnt), (k == 4) ? 32'h1 : 32'h0);
            chk("t6_seq_ls", 32'(ls_gnt), (k == 4) ? 32'h0 : 32'h1);
            if (ls_gnt) ls_addr = ls_addr + 32'd4;
            if (if_gnt) if_addr = if_addr + 32'd4;
        end
        if_req = 0; ls_req = 0;
        step(); step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
